sim_ctrl: RTL

Memory-mapped simulation-control peripheral on the tinyriscv SoC data bus. Firmware writes a pass/fail verdict, console characters and an optional cycle timeout. The block buffers console bytes in a small FIFO and exposes a clean done/pass/timeout status only after all buffered output has drained. The Verilator bench consumes `done_o`/`pass_o` and the console stream instead of snooping GPRs x26/x27.

---
 rtl/sim_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/sim_ctrl.sv
// Simulation-control peripheral: verdict/timeout registers, console byte FIFO and
// a RUN/DRAIN/HALT sequencer that only reports done once the console has drained.
module sim_ctrl #(
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter logic [31:0] DEFAULT_TIMEOUT = 32'd0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] data_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    output logic        done_o,
    output logic        pass_o,
    output logic        timeout_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALT
    } state_e;

    state_e             state_q, state_d;
    logic               pass_q, pass_d;
    logic               tmo_flag_q, tmo_flag_d;
    logic [31:0]        cycle_q;
    logic [31:0]        tmo_reg_q;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               rvalid_q;
    logic [31:0]        rdata_q, rdata_d;
    logic               done_q, pass_out_q, tmo_out_q;

    logic [1:0]         sel;
    logic               fifo_full, console_wr, stall, wr_acc;
    logic               push, pop, ctrl_done, timeout_hit;
    logic               unused_addr;

    assign unused_addr = ^{addr_i[31:4], addr_i[1:0]};

    assign sel        = addr_i[3:2];
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign console_wr = req_i && we_i && (sel == 2'd1);
    // In HALT console bytes are discarded, so a full FIFO never stalls there.
    assign stall      = console_wr && fifo_full && (state_q != HALT);
    assign gnt_o      = rst_ni && req_i && !stall;
    assign wr_acc     = gnt_o && we_i;
    assign push       = wr_acc && (sel == 2'd1) && be_i[0] && (state_q != HALT);
    assign pop        = tx_valid_o && tx_ready_i;
    assign ctrl_done  = wr_acc && (sel == 2'd0) && be_i[0] && data_i[0];
    assign timeout_hit = (tmo_reg_q != '0) && (cycle_q >= tmo_reg_q);

    assign tx_valid_o = (count_q != '0);
    assign tx_data_o  = tx_valid_o ? mem_q[rd_ptr_q] : '0;
    assign rvalid_o   = rvalid_q;
    assign data_o     = rdata_q;
    assign done_o     = done_q;
    assign pass_o     = pass_out_q;
    assign timeout_o  = tmo_out_q;

    always_comb begin
        state_d    = state_q;
        pass_d     = pass_q;
        tmo_flag_d = tmo_flag_q;
        case (state_q)
            RUN: begin
                if (ctrl_done) begin
                    state_d    = DRAIN;
                    pass_d     = data_i[1];
                    tmo_flag_d = 1'b0;
                end else if (timeout_hit) begin
                    state_d    = DRAIN;
                    pass_d     = 1'b0;
                    tmo_flag_d = 1'b1;
                end
            end
            DRAIN: begin
                if ((count_q == '0) && !push) begin
                    state_d = HALT;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        rdata_d = '0;
        case (sel)
            2'd0:    rdata_d = {29'b0, tmo_flag_q, pass_q, (state_q != RUN)};
            2'd1:    rdata_d = 32'(count_q);
            2'd2:    rdata_d = tmo_reg_q;
            default: rdata_d = cycle_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= RUN;
            pass_q     <= 1'b0;
            tmo_flag_q <= 1'b0;
            cycle_q    <= '0;
            tmo_reg_q  <= DEFAULT_TIMEOUT;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
            pass_out_q <= 1'b0;
            tmo_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pass_q     <= pass_d;
            tmo_flag_q <= tmo_flag_d;
            rvalid_q   <= gnt_o;
            rdata_q    <= (gnt_o && !we_i) ? rdata_d : '0;
            done_q     <= (state_d == HALT);
            pass_out_q <= (state_d == HALT) && pass_d;
            tmo_out_q  <= (state_d == HALT) && tmo_flag_d;

            // Holding CYCLE on the timeout cycle leaves it reading exactly TIMEOUT.
            if ((state_q == RUN) && !timeout_hit && (cycle_q != '1)) begin
                cycle_q <= cycle_q + 32'd1;
            end

            if (wr_acc && (sel == 2'd2)) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (be_i[b]) begin
                        tmo_reg_q[8*b +: 8] <= data_i[8*b +: 8];
                    end
                end
            end

            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i[7:0];
        end
    end

endmodule
